multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
// - Main control FSM for the RISC-V multi-cycle core; drives the datapath's enables, mux selects and ALU op each cycle.
// - Consumes op/funct fields from the instruction register and zero/lt flags from the ALU.
// - Produces PCWrite, IRWrite, RegWrite and MemWrite strobes, plus the AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUControl selects.
// PARAMETERS
// - none. All encodings are fixed constants in the shared package.
// PORTS
// - clk        in   1  core clock; every state change on its rising edge
// - rst        in   1  synchronous, active-high reset
// - op         in   7  Instr[6:0]
// - funct3     in   3  Instr[14:12]
// - funct7b5   in   1  Instr[30]
// - zero       in   1  ALU SrcA==SrcB
// - lt         in   1  ALU signed SrcA<SrcB
// - PCWrite    out  1  PC register enable
// - AdrSrc     out  1  memory address select: 0=PC, 1=Result
// - MemWrite   out  1  data memory write strobe
// - IRWrite    out  1  enables the Instr and OldPC registers
// - RegWrite   out  1  register file write strobe
// - ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
// - ALUSrcA    out  2  00=PC, 01=OldPC, 10=A register
// - ALUSrcB    out  2  00=B register, 01=ImmExt, 10=constant 4
// - ImmSrc     out  3  000=I, 001=S, 010=B, 011=J, 100=U
// - ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 100 passB, 101 slt, 111 xor
// - illegal_op out  1  one-cycle pulse in DECODE when op is unsupported
// - instr_done out  1  one-cycle pulse in the final state of each instruction
// BEHAVIOUR
// - State register: synchronous reset to FETCH. Outputs are a Moore decode of state; ImmSrc decodes from op alone.
// - While rst=1: PCWrite, MemWrite, IRWrite, RegWrite, illegal_op and instr_done are forced to 0.
// - Defaults in every state: all strobes 0, selects 0, ALUControl=add.
// - FETCH: AdrSrc=0, IRWrite=1, A=00, B=10, add, ResultSrc=10, PCWrite=1 (PC <= PC+4). Next state: DECODE.
// - DECODE: A=01, B=01, add (ALUOut <= OldPC+imm). Dispatch on op:
//   - 0000011 / 0100011 -> MEMADR
//   - 0110011 -> EXECR; 0010011 -> EXECI
//   - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI
//   - any other op -> FETCH, with illegal_op=1 and instr_done=1 (executes as a NOP)
// - MEMADR: A=10, B=01, add. Next state: MEMREAD for lw, MEMWRITE for sw.
// - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
// - MEMWB: ResultSrc=01, RegWrite=1, done. Next: FETCH.
// - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, done. Next: FETCH.
// - EXECR: A=10, B=00, ALUControl per funct3/funct7b5:
//   - add/sub, and, or, slt, xor
//   - unsupported funct3 -> add
//   - Next: ALUWB.
// - EXECI: A=10, B=01. Same decode, except funct7b5 is ignored (no subi). Next: ALUWB.
// - ALUWB: ResultSrc=00, RegWrite=1, done. Next: FETCH.
// - BRANCH: A=10, B=00, sub, ResultSrc=00. PCWrite = taken, done. Next: FETCH.
//   - beq(000): zero; bne(001): !zero; blt(100): lt; bge(101): !lt; other funct3: not taken
// - JAL: ResultSrc=00, PCWrite=1 (PC <= OldPC+imm). Next: LINK.
// - JALR: A=10, B=01, add, ResultSrc=10, PCWrite=1 (PC <= rs1+imm, bit0 not cleared). Next: LINK.
// - LINK: A=01, B=10, add, ResultSrc=10, RegWrite=1 (rd <= OldPC+4), done. Next: FETCH.
//   - rd==rs1 on jalr is safe: the target was already taken in the JALR state.
// - LUI: B=01, passB, ResultSrc=10, RegWrite=1, done. Next: FETCH.
// - Latency in cycles: R/I 4, lw 5, sw 4, branch 3, jal/jalr 4, lui 3.
// - Reset mid-instruction: the next cycle is FETCH, and no strobe fires in the reset cycle.
// - Flags are sampled only in BRANCH. zero/lt are don't-care in every other state.
// STRUCTURE
// - Package riscv_mc_pkg holds:
//   - state enum (4 bits)
//   - opcode constants
//   - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB code constants
// - Sub-module alu_decoder (combinational): takes alu_op class (add/sub/funct) plus funct3/funct7b5/op[5], returns ALUControl.
// - Everything else is in this module: state register, next-state logic, output decode.
// TESTING
// - addi x1,x0,5 (op 0010011): FETCH,DECODE,EXECI,ALUWB. RegWrite only in cycle 4, ALUControl=000, instr_done once.
// - lw: 5 cycles. AdrSrc=1 in MEMREAD/MEMWB, ResultSrc=01 with RegWrite in cycle 5, MemWrite never 1.
// - sw: MemWrite=1 in cycle 4 only, RegWrite never 1.
// - beq with zero=1: PCWrite=1 in cycle 3. With zero=0: PCWrite=0. Repeat for bne/blt/bge, both lt values.
// - jal: PCWrite with ResultSrc=00 in cycle 3; RegWrite with ResultSrc=10, A=01, B=10 in cycle 4.
// - op=0000000: illegal_op=1 in DECODE, then FETCH. Also rst=1 during MEMREAD: no strobes, FETCH on the next cycle.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the RISC-V multi-cycle control path: FSM states,
// opcodes and every datapath select/ALU code the controller drives.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b111;

  // Operation class handed to alu_decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class plus funct fields to ALUControl.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_PASSB: alu_control = ALU_PASSB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type so addi with imm[10]=1 never subtracts
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the RISC-V multi-cycle core: state register, next-state
// logic and Moore decode of the datapath enables, selects and ALU operation.
module multi_cycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic       taken;
  logic       pc_write, mem_write, ir_write, reg_write, illegal, done;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMADR:        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:       next_state = S_MEMWB;
      S_EXECR, S_EXECI: next_state = S_ALUWB;
      S_JAL, S_JALR:   next_state = S_LINK;
      default:         next_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    done      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_B;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
          default:                            illegal = 1'b1;
        endcase
        done = illegal;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        alu_op   = ALUOP_SUB;
        pc_write = taken;
        done     = 1'b1;
      end
      S_JAL: pc_write = 1'b1;
      S_JALR: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_write  = 1'b1;
      end
      // Link after the jump so jalr with rd==rs1 has already used the old rs1
      S_LINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_LUI: begin
        ALUSrcB   = SRCB_IMM;
        alu_op    = ALUOP_PASSB;
        ResultSrc = RES_ALURESULT;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      OP_LUI:    ImmSrc = IMM_U;
      default:   ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  assign PCWrite    = pc_write  && !rst;
  assign MemWrite   = mem_write && !rst;
  assign IRWrite    = ir_write  && !rst;
  assign RegWrite   = reg_write && !rst;
  assign illegal_op = illegal   && !rst;
  assign instr_done = done      && !rst;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic       illegal_op, instr_done;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       ill;
    logic       done;
  } outs_t;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_ILL} kind_t;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .lt         (lt),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  function automatic kind_t classify(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:              return 5;
      K_SW, K_R, K_I:    return 4;
      K_JAL, K_JALR:     return 4;
      K_BR, K_LUI:       return 3;
      default:           return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input kind_t k);
    case (k)
      K_SW:    return 3'b001;
      K_BR:    return 3'b010;
      K_JAL:   return 3'b011;
      K_LUI:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_req);
    case (f3)
      3'b000:  return sub_req ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      3'b100:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for cycle cyc (1-based) of an instruction
  function automatic outs_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input int cyc, input logic z, input logic l);
    outs_t e;
    kind_t k;
    k     = classify(o);
    e     = '0;
    e.imm = imm_of(k);
    if (cyc == 1) begin
      e.pcw = 1; e.irw = 1; e.sb = 2'b10; e.res = 2'b10;
    end else if (cyc == 2) begin
      e.sa = 2'b01; e.sb = 2'b01;
      if (k == K_ILL) begin e.ill = 1; e.done = 1; end
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (cyc == 3) begin e.sa = 2'b10; e.sb = 2'b01; end
          else if (cyc == 4 && k == K_SW) begin e.adr = 1; e.memw = 1; e.done = 1; end
          else if (cyc == 4) e.adr = 1;
          else begin e.adr = 1; e.res = 2'b01; e.regw = 1; e.done = 1; end
        end
        K_R, K_I: begin
          if (cyc == 3) begin
            e.sa  = 2'b10;
            e.sb  = (k == K_I) ? 2'b01 : 2'b00;
            e.alu = alu_of(f3, (k == K_R) && f7);
          end else begin
            e.regw = 1; e.done = 1;
          end
        end
        K_BR: begin
          e.sa = 2'b10; e.alu = 3'b001; e.pcw = branch_taken(f3, z, l); e.done = 1;
        end
        K_JAL, K_JALR: begin
          if (cyc == 3 && k == K_JAL) e.pcw = 1;
          else if (cyc == 3) begin e.sa = 2'b10; e.sb = 2'b01; e.res = 2'b10; e.pcw = 1; end
          else begin e.sa = 2'b01; e.sb = 2'b10; e.res = 2'b10; e.regw = 1; e.done = 1; end
        end
        K_LUI: begin
          e.sb = 2'b01; e.alu = 3'b100; e.res = 2'b10; e.regw = 1; e.done = 1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; leaves it likewise.
  // rst_at>0 asserts reset during that cycle and abandons the instruction.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input bit rnd, input logic z, input logic l,
                           input int rst_at);
    outs_t got, exp;
    int n;
    n = latency(classify(o));
    op = o; funct3 = f3; funct7b5 = f7;
    for (int c = 1; c <= n; c++) begin
      if (rnd) begin
        zero = 1'($urandom_range(0, 1));
        lt   = 1'($urandom_range(0, 1));
      end else begin
        zero = z; lt = l;
      end
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, illegal_op, instr_done};
      checks++;
      if (c == rst_at) begin
        if ({PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, instr_done} !== 6'b0)
          $display("FAIL %s reset in cycle %0d: strobes %b, required 000000", name, c,
                   {PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, instr_done});
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      exp = model(o, f3, f7, c, zero, lt);
      if (got !== exp)
        $display("FAIL %s cycle %0d: outputs %h, required %h", name, c, got, exp);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 1; lt = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, instr_done} !== 6'b0)
      $display("FAIL reset strobes: %b, required 000000",
               {PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, instr_done});
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    run_instr("addi", 7'b0010011, 3'b000, 1'b0, 1, 0, 0, 0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1, 0, 0, 0);
    for (int f = 0; f < 8; f++) begin
      run_instr("rtype_add", 7'b0110011, 3'(f), 1'b0, 1, 0, 0, 0);
      run_instr("rtype_sub", 7'b0110011, 3'(f), 1'b1, 1, 0, 0, 0);
      run_instr("itype", 7'b0010011, 3'(f), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
    end
  endtask

  task automatic test_mem();
    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1, 0, 0, 0);
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1, 0, 0, 0);
  endtask

  task automatic test_branches();
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
    foreach (f3s[i])
      for (int zl = 0; zl < 4; zl++)
        run_instr("branch", 7'b1100011, f3s[i], 1'b0, 0, zl[0], zl[1], 0);
  endtask

  task automatic test_jumps();
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1, 0, 0, 0);
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0, 1, 0, 0, 0);
    run_instr("lui", 7'b0110111, 3'b101, 1'b1, 1, 0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_zero", 7'b0000000, 3'b000, 1'b0, 1, 0, 0, 0);
    run_instr("after_illegal", 7'b0010011, 3'b100, 1'b0, 1, 0, 0, 0);
    run_instr("auipc_illegal", 7'b0010111, 3'b000, 1'b0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_instr("rst_memread", 7'b0000011, 3'b010, 1'b0, 1, 0, 0, 4);
    run_instr("post_rst_lw", 7'b0000011, 3'b010, 1'b0, 1, 0, 0, 0);
    run_instr("rst_memwrite", 7'b0100011, 3'b010, 1'b0, 1, 0, 0, 4);
    run_instr("rst_fetch", 7'b0110011, 3'b000, 1'b0, 1, 0, 0, 1);
    run_instr("rst_jal", 7'b1101111, 3'b000, 1'b0, 1, 0, 0, 3);
    run_instr("rst_decode_ill", 7'b1111111, 3'b000, 1'b0, 1, 0, 0, 2);
    run_instr("post_rst_r", 7'b0110011, 3'b111, 1'b0, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal [8];
    logic [6:0] o;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do o = 7'($urandom); while (classify(o) != K_ILL);
      end else begin
        o = legal[$urandom_range(0, 7)];
      end
      run_instr("random", o, 3'($urandom), 1'($urandom), 1, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_mem();
    test_branches();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
